// File: rtl/wr_port_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write-port arbiter.
// Imported by the arbiter top level and its bench.
package wr_port_arbiter_pkg;

    localparam int WR_PORT_NUM   = 9;
    localparam int WR_PORT_SEL_W = 16;

    typedef enum logic [1:0] {
        WRARB_IDLE   = 2'd0,
        WRARB_GRANT  = 2'd1,
        WRARB_LOCKED = 2'd2
    } wrarb_state_t;

endpackage

// File: rtl/rr_find_first.sv
// Round-robin search: rotate req by ptr, find the first set bit, rotate the index back.
// Purely combinational; ptr is expected to be below N.
module rr_find_first #(
    parameter int N     = 9,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [N-1:0] rot;
    int           first;
    int           src;
    int           sum;

    // rot[k] is the requester k positions after ptr, so bit 0 has top priority
    always_comb begin
        rot   = '0;
        src   = 0;
        first = 0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            src = k + int'(ptr);
            if (src >= N) src = src - N;
            rot[k] = req[IDX_W'(src)];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                first = i;
            end
        end
        sum = first + int'(ptr);
        if (sum >= N) sum = sum - N;
        winner = IDX_W'(sum);
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin owner selection for one register-file write port, with locked bursts
// and a forced release after MAX_LOCK consecutive cycles.
module wr_port_arbiter
    import wr_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = WR_PORT_NUM,
    parameter int MAX_LOCK  = 8,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PORTS-1:0]     req,
    input  logic [NUM_PORTS-1:0]     lock,
    output logic [WR_PORT_SEL_W-1:0] wr_port_select,
    output logic [NUM_PORTS-1:0]     grant,
    output logic                     busy,
    output logic                     lock_timeout
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    wrarb_state_t         state, state_next;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_next;
    logic [PTR_W-1:0]     owner, owner_next;
    logic [CNT_W-1:0]     lock_cnt, lock_cnt_next;
    logic [NUM_PORTS-1:0] grant_next;
    logic                 timeout_next;
    logic [PTR_W-1:0]     winner;
    logic                 winner_valid;
    logic                 owner_locked;

    rr_find_first #(.N(NUM_PORTS), .IDX_W(PTR_W)) u_find (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (winner),
        .valid  (winner_valid)
    );

    assign owner_locked = (state == WRARB_LOCKED) && req[owner] && lock[owner];

    // Either extend the current burst or re-arbitrate; rr_ptr already sits one past the owner
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        owner_next    = owner;
        lock_cnt_next = lock_cnt;
        grant_next    = grant;
        timeout_next  = 1'b0;
        if (owner_locked && (lock_cnt < CNT_W'(MAX_LOCK))) begin
            lock_cnt_next = lock_cnt + 1'b1;
        end else begin
            timeout_next = owner_locked;
            grant_next   = '0;
            if (winner_valid) begin
                grant_next[winner] = 1'b1;
                owner_next         = winner;
                rr_ptr_next        = (winner == PTR_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
                if (lock[winner]) begin
                    state_next    = WRARB_LOCKED;
                    lock_cnt_next = CNT_W'(1);
                end else begin
                    state_next    = WRARB_GRANT;
                    lock_cnt_next = '0;
                end
            end else begin
                state_next    = WRARB_IDLE;
                lock_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WRARB_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            lock_cnt     <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_next;
            rr_ptr       <= rr_ptr_next;
            owner        <= owner_next;
            lock_cnt     <= lock_cnt_next;
            grant        <= grant_next;
            busy         <= |grant_next;
            lock_timeout <= timeout_next;
        end
    end

    assign wr_port_select = WR_PORT_SEL_W'(grant);

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Self-checking bench for wr_port_arbiter: vector table, directed burst/reset
// sequences and randomized traffic against a rule-level reference model.
module tb_wr_port_arbiter;
    import wr_port_arbiter_pkg::*;

    localparam int N   = 9;
    localparam int MAX = 8;

    logic                     clk;
    logic                     rst_n;
    logic [N-1:0]             req;
    logic [N-1:0]             lock;
    logic [WR_PORT_SEL_W-1:0] wr_port_select;
    logic [N-1:0]             grant;
    logic                     busy;
    logic                     lock_timeout;

    int checks;
    int errors;

    // reference model state, expressed as plain integers
    int           m_ptr;
    int           m_owner;
    int           m_cnt;
    bit           m_locked;
    logic [N-1:0] m_grant;
    bit           m_to;

    typedef struct {
        bit           rst_before;
        logic [N-1:0] v_req;
        logic [N-1:0] v_lock;
        logic [N-1:0] exp_grant;
        logic         exp_to;
    } vec_t;

    vec_t vecs[$];

    wr_port_arbiter #(.NUM_PORTS(N), .MAX_LOCK(MAX), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .lock           (lock),
        .wr_port_select (wr_port_select),
        .grant          (grant),
        .busy           (busy),
        .lock_timeout   (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_locked = 0;
        m_grant  = '0;
        m_to     = 0;
    endtask

    // one clock edge worth of arbitration rules
    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] l);
        int  found;
        bit  still;
        still = m_locked && r[m_owner] && l[m_owner];
        m_to  = 0;
        if (still && m_cnt < MAX) begin
            m_cnt++;
        end else begin
            m_to  = still;
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && r[(m_ptr + k) % N]) found = (m_ptr + k) % N;
            end
            if (found >= 0) begin
                m_grant  = '0;
                m_grant[found] = 1'b1;
                m_ptr    = (found + 1) % N;
                m_owner  = found;
                m_locked = l[found];
                m_cnt    = 1;
            end else begin
                m_grant  = '0;
                m_locked = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r, input logic [N-1:0] l);
        @(negedge clk);
        req  = r;
        lock = l;
        model_edge(r, l);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_output({tag, ".grant"}, 16'(grant), 16'(m_grant));
        check_output({tag, ".sel"}, wr_port_select, 16'(m_grant));
        check_output({tag, ".busy"}, 16'(busy), 16'(|m_grant));
        check_output({tag, ".timeout"}, 16'(lock_timeout), 16'(m_to));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        lock   = '0;
        model_reset();

        // single request, then rr_ptr=5 shows up as port 5 winning a full request
        vecs.push_back('{1'b1, 9'h010, 9'h000, 9'h010, 1'b0});
        vecs.push_back('{1'b0, 9'h000, 9'h000, 9'h000, 1'b0});
        vecs.push_back('{1'b0, 9'h1FF, 9'h000, 9'h020, 1'b0});
        vecs.push_back('{1'b0, 9'h000, 9'h000, 9'h000, 1'b0});
        // short burst on port 0, port 2 waiting
        vecs.push_back('{1'b1, 9'h005, 9'h001, 9'h001, 1'b0});
        vecs.push_back('{1'b0, 9'h005, 9'h001, 9'h001, 1'b0});
        vecs.push_back('{1'b0, 9'h005, 9'h001, 9'h001, 1'b0});
        vecs.push_back('{1'b0, 9'h004, 9'h000, 9'h004, 1'b0});
        vecs.push_back('{1'b0, 9'h000, 9'h000, 9'h000, 1'b0});
        // port 2 withdraws while port 0 holds a burst; only port 6 follows
        vecs.push_back('{1'b1, 9'h045, 9'h001, 9'h001, 1'b0});
        vecs.push_back('{1'b0, 9'h045, 9'h001, 9'h001, 1'b0});
        vecs.push_back('{1'b0, 9'h041, 9'h001, 9'h001, 1'b0});
        vecs.push_back('{1'b0, 9'h040, 9'h000, 9'h040, 1'b0});
        vecs.push_back('{1'b0, 9'h000, 9'h000, 9'h000, 1'b0});

        #3;
        check_output("reset.grant", 16'(grant), 16'h0000);
        check_output("reset.sel", wr_port_select, 16'h0000);
        check_output("reset.busy", 16'(busy), 16'h0000);
        check_output("reset.timeout", 16'(lock_timeout), 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            apply_stimulus(vecs[i].v_req, vecs[i].v_lock);
            check_output($sformatf("vec%0d.grant", i), 16'(grant), 16'(vecs[i].exp_grant));
            check_output($sformatf("vec%0d.sel", i), wr_port_select, 16'(vecs[i].exp_grant));
            check_output($sformatf("vec%0d.busy", i), 16'(busy), 16'(|vecs[i].exp_grant));
            check_output($sformatf("vec%0d.timeout", i), 16'(lock_timeout), 16'(vecs[i].exp_to));
        end

        // all ports requesting: strict rotation with no idle cycle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(9'h1FF, 9'h000);
            check_output($sformatf("rot%0d.grant", i), 16'(grant), 16'(1) << (i % N));
            check_output($sformatf("rot%0d.onehot", i), 16'($onehot(wr_port_select)), 16'h0001);
        end

        // port 3 locks forever, port 7 waits: forced release after MAX cycles
        do_reset();
        for (int i = 0; i < MAX; i++) begin
            apply_stimulus(9'h088, 9'h008);
            check_output($sformatf("to%0d.grant", i), 16'(grant), 16'h0008);
            check_output($sformatf("to%0d.timeout", i), 16'(lock_timeout), 16'h0000);
        end
        apply_stimulus(9'h088, 9'h008);
        check_output("to_rel.grant", 16'(grant), 16'h0080);
        check_output("to_rel.timeout", 16'(lock_timeout), 16'h0001);
        apply_stimulus(9'h088, 9'h008);
        check_output("to_after.grant", 16'(grant), 16'h0008);
        check_output("to_after.timeout", 16'(lock_timeout), 16'h0000);

        // asynchronous reset in the middle of a burst
        do_reset();
        apply_stimulus(9'h008, 9'h008);
        apply_stimulus(9'h008, 9'h008);
        check_output("mid.grant_before", 16'(grant), 16'h0008);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid.grant", 16'(grant), 16'h0000);
        check_output("mid.sel", wr_port_select, 16'h0000);
        check_output("mid.busy", 16'(busy), 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(9'h100, 9'h000);
        check_output("mid.after", 16'(grant), 16'h0100);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(N'($urandom & $urandom), N'($urandom & $urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
